// File: rtl/alarme.sv
// Intruder-alarm controller: synchronizes door/window/motion/arm inputs and
// latches a registered siren output while the system stays armed.
module alarme #(
    parameter int SYNC_STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic P,
    input  logic W,
    input  logic M,
    input  logic S,
    output logic A
);

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        ALARM    = 2'b10
    } state_t;

    // One 4-bit word per synchronizer stage: {P, W, M, S}
    logic [SYNC_STAGES-1:0][3:0] sync;
    logic   ps, ws, ms, ss, trig;
    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync[0] <= {P, W, M, S};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
        end
    end

    assign {ps, ws, ms, ss} = sync[SYNC_STAGES-1];
    assign trig = ps | ws | ms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DISARMED;
            A     <= 1'b0;
        end else begin
            state <= state_nxt;
            // Own flop so A tracks the state without decoding, and an
            // illegal encoding can never raise the siren.
            A     <= (state_nxt == ALARM);
        end
    end

    always_comb begin
        state_nxt = DISARMED;
        case (state)
            DISARMED: begin
                if (ss && trig)  state_nxt = ALARM;
                else if (ss)     state_nxt = ARMED;
                else             state_nxt = DISARMED;
            end
            ARMED: begin
                if (!ss)         state_nxt = DISARMED;
                else if (trig)   state_nxt = ALARM;
                else             state_nxt = ARMED;
            end
            ALARM: begin
                // Latched until disarmed, even after the sensors clear
                if (!ss)         state_nxt = DISARMED;
                else             state_nxt = ALARM;
            end
            default:             state_nxt = DISARMED;
        endcase
    end

endmodule

// File: tb/tb_alarme.sv
// Directed bench for alarme: expected A values are queued as stimulus is
// applied and popped/compared one per sampled clock.
module tb_alarme;

    logic clk = 1'b0;
    logic rst_n, P, W, M, S;
    logic A;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        logic  exp;
    } sb_t;

    sb_t sbq[$];

    alarme #(.SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .P    (P),
        .W    (W),
        .M    (M),
        .S    (S),
        .A    (A)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        sb_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow got empty queue exp entry");
        end else begin
            e = sbq.pop_front();
            assert (A === e.exp) else begin
                errors++;
                $error("FAIL %s got %b exp %b", e.tag, A, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] pwms);
        @(negedge clk);
        {P, W, M, S} = pwms;
    endtask

    task automatic hold_then(input int n, input string tag, input logic exp);
        repeat (n) tick();
        push(tag, exp);
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0;
        {P, W, M, S} = 4'b1111;

        // Reset held with all inputs active
        #3;
        push("rst_immediate", 1'b0);
        pop_check();
        repeat (3) begin
            tick();
            push("rst_held", 1'b0);
            pop_check();
        end

        // Release between edges; alarm appears on the 3rd edge
        @(negedge clk);
        rst_n = 1'b1;
        push("rel_e1", 1'b0);
        push("rel_e2", 1'b0);
        push("rel_e3", 1'b1);
        repeat (3) begin
            tick();
            pop_check();
        end

        // Exhaustive PWMS sweep in binary order
        for (int v = 0; v < 16; v++) begin
            logic [3:0] pat;
            pat = 4'(v);
            drive(pat);
            hold_then(20, $sformatf("sweep_%b", pat), pat[0] & (|pat[3:1]));
        end

        // Latch: disarm, arm idle, then a 3-cycle window pulse
        drive(4'b0000);
        hold_then(5, "latch_disarm", 1'b0);
        drive(4'b0001);
        hold_then(10, "latch_armed_idle", 1'b0);
        drive(4'b0101);
        push("latch_e1", 1'b0);
        push("latch_e2", 1'b0);
        push("latch_e3", 1'b1);
        repeat (3) begin
            tick();
            pop_check();
        end
        drive(4'b0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            push($sformatf("latch_hold_%0d", i), 1'b1);
            pop_check();
        end
        drive(4'b0000);
        push("unlatch_e1", 1'b1);
        push("unlatch_e2", 1'b1);
        push("unlatch_e3", 1'b0);
        repeat (3) begin
            tick();
            pop_check();
        end

        // Priority: S falls in the same cycle M rises
        drive(4'b0001);
        hold_then(10, "prio_armed", 1'b0);
        drive(4'b0010);
        for (int i = 0; i < 8; i++) begin
            tick();
            push($sformatf("prio_%0d", i), 1'b0);
            pop_check();
        end

        // Latency: arm, then assert P just before edge n
        drive(4'b0000);
        hold_then(4, "lat_disarm", 1'b0);
        drive(4'b0001);
        hold_then(10, "lat_armed", 1'b0);
        drive(4'b1001);
        push("lat_n", 1'b0);
        push("lat_n1", 1'b0);
        push("lat_n2", 1'b1);
        repeat (3) begin
            tick();
            pop_check();
        end

        // Async reset mid-alarm, pulsed between edges
        hold_then(5, "mid_alarm", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        push("async_drop", 1'b0);
        pop_check();
        #1;
        rst_n = 1'b1;
        push("rearm_e1", 1'b0);
        push("rearm_e2", 1'b0);
        push("rearm_e3", 1'b1);
        repeat (3) begin
            tick();
            pop_check();
        end

        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover got %0d exp 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
